ysyx_23060203_wbu: RTL and testbench
====================================

# ysyx_23060203_wbu

Write-back stage of the ysyx_23060203 in-order pipeline. It sits directly downstream of the execute stage and commits each retiring instruction's GPR and CSR results. It owns the 32×32 general-purpose register file and the machine-mode CSR file, and serves their combinational read ports to the decode stage. It also detects ebreak (a CSR write to address 0x000), halts the pipeline, and keeps the mcycle and minstret counters.

## Interface
Parameters:
- NR_GPR, 32, number of architectural GPRs; x0 is hardwired to zero.
- MVENDORID, 32'h7973_7978, reset and fixed value of mvendorid (ASCII "ysyx").
- MARCHID, 32'h015F_DEEB, fixed value of marchid (decimal 23060203).

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_ready  out  1  1 while in RUN, 0 while in HALT
- in_valid  in  1  execute stage has a retiring instruction
- in_gpr_waddr  in  5  destination GPR; 0 means no GPR write
- in_gpr_wdata  in  32  GPR write data
- in_csr_wen  in  1  CSR write request
- in_csr_waddr  in  12  CSR address; 0x000 with in_csr_wen set means ebreak
- in_csr_wdata  in  32  CSR write data
- rs1_addr, rs2_addr  in  5  decode-stage GPR read addresses
- rs1_data, rs2_data  out  32  GPR read data, combinational
- csr_raddr  in  12  decode-stage CSR read address
- csr_rdata  out  32  CSR read data, combinational; 0 for unimplemented addresses
- halt  out  1  level signal, high in HALT; resets to 0
- halt_code  out  32  value of x10 (a0) captured at ebreak; resets to 0
- commit  out  1  registered one-cycle pulse per retired instruction; resets to 0

## Operation
- Commit occurs when `in_valid & in_ready`. All architectural writes happen at that clock edge.
- GPR write:
  - When `in_gpr_waddr != 0`, write `in_gpr_wdata` to that register.
  - x0 always reads 0.
- CSR write:
  - Writable CSRs: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342, mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82.
  - mvendorid 0xF11 and marchid 0xF12 are read-only; writes to them are silently dropped.
  - Writes to unimplemented addresses are dropped.
- Reset values: all GPRs are 0; mstatus is 32'h0000_1800; every other writable CSR is 0.
- Counters:
  - mcycle is 64 bits and increments every non-reset cycle, including cycles spent in HALT.
  - minstret is 64 bits and increments on each commit.
  - Both wrap from 2^64-1 to 0.
  - If a CSR write targets a counter half in the same cycle as an increment, the written value is stored and that cycle's increment is lost. The other half is unaffected, with no carry into it.
- Read bypass:
  - If a GPR read address equals a nonzero committing `in_gpr_waddr`, the read returns `in_gpr_wdata`.
  - If `csr_raddr` equals the committing writable `in_csr_waddr`, `csr_rdata` returns `in_csr_wdata`.
- State machine:
  - RUN → HALT when a commit carries `in_csr_wen=1` and `in_csr_waddr=0`.
  - On that edge, `halt_code` captures x10, using the bypass value if the same commit also writes x10.
  - HALT is left only by reset.
  - An ebreak's own GPR write still takes effect.

## Timing
- Zero-cycle acceptance: `in_ready` is a pure function of state, 1 in RUN. The execute stage's output never stalls on this block.
- Written state is visible through the registered path one cycle after commit; the bypass covers the commit cycle itself.
- `commit` pulses in the cycle after each commit edge.
- `halt` rises in the cycle after the ebreak commit. `in_ready` falls in that same cycle.
- Reset mid-operation: the next edge with reset high restores every reset value and RUN. Any in-flight `in_valid` is ignored that cycle.

## Structure
- Shared package `ysyx_23060203_pkg` holds:
  - the CSR address localparams (CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE, CSR_MCYCLE(H), CSR_MINSTRET(H), CSR_MVENDORID, CSR_MARCHID, CSR_EBREAK=12'h000);
  - the state enum `wbu_state_e {WBU_RUN, WBU_HALT}`.
- One sub-module, `ysyx_23060203_GPR`: the register file with 1 write port, 2 read ports, x0 hardwiring and the write-read bypass.
- The CSR file, the counters and the FSM live in the top module.

## Test plan
- After reset, read all GPRs and the CSRs at 0x300, 0xF11 and 0xF12 → 0, 32'h0000_1800, 32'h7973_7978 and 32'h015F_DEEB respectively; `halt`=0 and `in_ready`=1.
- Commit waddr=5, wdata=32'hDEAD_BEEF with rs1_addr=5 in the same cycle → rs1_data=32'hDEAD_BEEF that cycle and after. Then commit waddr=0, wdata=1 → rs2_addr=0 reads 0.
- Write 0x305=32'h8000_0100, then 0xF11=0 → mtvec reads 32'h8000_0100 and mvendorid still reads 32'h7973_7978.
- Write mcycle=32'hFFFF_FFFF with mcycleh=0 → two cycles later mcycleh=1, mcycle=1. Retire 3 instructions from reset → minstret=3 and `commit` pulses 3 times.
- Set x10=42, then commit csr_wen=1, csr_waddr=0 → next cycle `halt`=1, `halt_code`=42, `in_ready`=0. Further `in_valid` leaves GPRs and minstret unchanged, while mcycle keeps counting.
- Assert reset while in HALT → next cycle `halt`=0, `in_ready`=1, x10=0 and mcycle=0.

Source files
------------

// File: rtl/ysyx_23060203_pkg.sv
// Shared definitions for the ysyx_23060203 write-back stage: CSR map and FSM states.
package ysyx_23060203_pkg;

  localparam logic [11:0] CSR_EBREAK    = 12'h000;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;

  // MPP = machine mode out of reset
  localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;

  typedef enum logic [0:0] {WBU_RUN, WBU_HALT} wbu_state_e;

  // True for addresses that accept software writes (read-only and unimplemented drop them)
  function automatic logic csr_writable(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE,
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060203_GPR.sv
// General-purpose register file: one write port, two decode read ports plus a0 tap,
// x0 hardwired to zero, write-to-read bypass during the commit cycle.
module ysyx_23060203_GPR #(
  parameter int NR_GPR = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wen,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [31:0] a0_data
);

  logic [31:0] regs_q [NR_GPR];

  // Register storage; x0 is never written
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NR_GPR; i++) regs_q[i] <= '0;
    end else if (wen && waddr != 5'd0) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Read ports with bypass of the write committing this cycle
  always_comb begin
    rs1_data = (rs1_addr == 5'd0) ? 32'd0 : regs_q[rs1_addr];
    rs2_data = (rs2_addr == 5'd0) ? 32'd0 : regs_q[rs2_addr];
    a0_data  = regs_q[10];
    if (wen && waddr != 5'd0) begin
      if (rs1_addr == waddr) rs1_data = wdata;
      if (rs2_addr == waddr) rs2_data = wdata;
      if (waddr == 5'd10)    a0_data  = wdata;
    end
  end

endmodule

// File: rtl/ysyx_23060203_wbu.sv
// Write-back stage: commits GPR/CSR results, owns the CSR file and counters,
// and halts on ebreak (CSR write to address 0x000).
module ysyx_23060203_wbu
  import ysyx_23060203_pkg::*;
#(
  parameter int          NR_GPR    = 32,
  parameter logic [31:0] MVENDORID = 32'h7973_7978,
  parameter logic [31:0] MARCHID   = 32'h015F_DEEB
) (
  input  logic        clock,
  input  logic        reset,
  output logic        in_ready,
  input  logic        in_valid,
  input  logic [4:0]  in_gpr_waddr,
  input  logic [31:0] in_gpr_wdata,
  input  logic        in_csr_wen,
  input  logic [11:0] in_csr_waddr,
  input  logic [31:0] in_csr_wdata,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic [11:0] csr_raddr,
  output logic [31:0] csr_rdata,
  output logic        halt,
  output logic [31:0] halt_code,
  output logic        commit
);

  wbu_state_e  state_q, state_d;
  logic        fire, csr_we, ebreak;
  logic [31:0] a0_data;
  logic [31:0] mstatus_q, mtvec_q, mepc_q, mcause_q;
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic [31:0] halt_code_q;
  logic        commit_q;
  logic [31:0] csr_q;

  assign in_ready  = (state_q == WBU_RUN);
  assign fire      = in_valid & in_ready;
  assign csr_we    = fire & in_csr_wen;
  assign ebreak    = csr_we & (in_csr_waddr == CSR_EBREAK);
  assign halt      = (state_q == WBU_HALT);
  assign halt_code = halt_code_q;
  assign commit    = commit_q;

  ysyx_23060203_GPR #(
    .NR_GPR(NR_GPR)
  ) u_gpr (
    .clock    (clock),
    .reset    (reset),
    .wen      (fire),
    .waddr    (in_gpr_waddr),
    .wdata    (in_gpr_wdata),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .a0_data  (a0_data)
  );

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= WBU_RUN;
    else       state_q <= state_d;
  end

  // FSM next state: HALT is absorbing until reset
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WBU_RUN:  if (ebreak) state_d = WBU_HALT;
      WBU_HALT: state_d = WBU_HALT;
    endcase
  end

  // Counter next state; a CSR write to one half replaces that cycle's increment
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, fire};
    if (csr_we) begin
      case (in_csr_waddr)
        CSR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], in_csr_wdata};
        CSR_MCYCLEH:   mcycle_d   = {in_csr_wdata, mcycle_q[31:0]};
        CSR_MINSTRET:  minstret_d = {minstret_q[63:32], in_csr_wdata};
        CSR_MINSTRETH: minstret_d = {in_csr_wdata, minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  // CSR file, counters, halt code and commit pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      mstatus_q   <= MSTATUS_RESET;
      mtvec_q     <= '0;
      mepc_q      <= '0;
      mcause_q    <= '0;
      mcycle_q    <= '0;
      minstret_q  <= '0;
      halt_code_q <= '0;
      commit_q    <= 1'b0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      commit_q   <= fire;
      if (ebreak) halt_code_q <= a0_data;
      if (csr_we) begin
        case (in_csr_waddr)
          CSR_MSTATUS: mstatus_q <= in_csr_wdata;
          CSR_MTVEC:   mtvec_q   <= in_csr_wdata;
          CSR_MEPC:    mepc_q    <= in_csr_wdata;
          CSR_MCAUSE:  mcause_q  <= in_csr_wdata;
          default: ;
        endcase
      end
    end
  end

  // CSR read mux with bypass of a committing writable CSR
  always_comb begin
    case (csr_raddr)
      CSR_MSTATUS:   csr_q = mstatus_q;
      CSR_MTVEC:     csr_q = mtvec_q;
      CSR_MEPC:      csr_q = mepc_q;
      CSR_MCAUSE:    csr_q = mcause_q;
      CSR_MCYCLE:    csr_q = mcycle_q[31:0];
      CSR_MCYCLEH:   csr_q = mcycle_q[63:32];
      CSR_MINSTRET:  csr_q = minstret_q[31:0];
      CSR_MINSTRETH: csr_q = minstret_q[63:32];
      CSR_MVENDORID: csr_q = MVENDORID;
      CSR_MARCHID:   csr_q = MARCHID;
      default:       csr_q = 32'd0;
    endcase
    csr_rdata = csr_q;
    if (csr_we && csr_writable(in_csr_waddr) && csr_raddr == in_csr_waddr) begin
      csr_rdata = in_csr_wdata;
    end
  end

endmodule

// File: tb/tb_ysyx_23060203_wbu.sv
// Scoreboard bench for the write-back stage: stimulus updates a behavioural model and
// queues expectations; a monitor compares them when the DUT presents results.
module tb_ysyx_23060203_wbu;

  localparam logic [31:0] VENDOR = 32'h7973_7978;
  localparam logic [31:0] ARCH   = 32'h015F_DEEB;
  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_VENDOR   = 12'hF11;
  localparam logic [11:0] A_ARCH     = 12'hF12;
  localparam logic [11:0] A_UNIMPL   = 12'h7C0;
  localparam logic [11:0] A_NONE     = 12'hFFF;

  localparam int P_GPR = 0, P_RS1 = 1, P_CSR = 2, P_HALT = 3, P_READY = 4, P_CODE = 5;

  logic        clock, reset, in_ready, in_valid;
  logic [4:0]  in_gpr_waddr, rs1_addr, rs2_addr;
  logic [31:0] in_gpr_wdata, in_csr_wdata, rs1_data, rs2_data, csr_rdata, halt_code;
  logic        in_csr_wen, halt, commit;
  logic [11:0] in_csr_waddr, csr_raddr;

  ysyx_23060203_wbu dut (
    .clock        (clock),
    .reset        (reset),
    .in_ready     (in_ready),
    .in_valid     (in_valid),
    .in_gpr_waddr (in_gpr_waddr),
    .in_gpr_wdata (in_gpr_wdata),
    .in_csr_wen   (in_csr_wen),
    .in_csr_waddr (in_csr_waddr),
    .in_csr_wdata (in_csr_wdata),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .csr_raddr    (csr_raddr),
    .csr_rdata    (csr_rdata),
    .halt         (halt),
    .halt_code    (halt_code),
    .commit       (commit)
  );

  typedef struct {
    logic [4:0]  gaddr;
    logic [31:0] gdata;
    logic        chk_csr;
    logic [11:0] caddr;
    logic [31:0] cdata;
    logic [31:0] minstret;
  } commit_t;

  typedef struct {
    int          kind;
    logic [11:0] addr;
    logic [31:0] exp;
  } probe_t;

  commit_t     cq[$];
  probe_t      pq[$];
  int          checks = 0;
  int          errors = 0;
  logic        done = 1'b0;
  int unsigned edges = 0;

  // Behavioural model state
  logic [31:0] m_gpr [32];
  logic [31:0] m_csr [bit [11:0]];
  int unsigned m_minstret;
  logic        m_halted;
  logic [31:0] m_code;
  logic [11:0] csr_pool [7] = '{A_MSTATUS, A_MTVEC, A_MEPC, A_MCAUSE, A_VENDOR, A_ARCH, A_UNIMPL};

  initial clock = 1'b0;
  always #50 clock = ~clock;

  // Cycle count since the last reset edge: the architectural mcycle when software never writes it
  always @(posedge clock) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  function automatic logic [31:0] model_csr_read(input logic [11:0] a);
    if (m_csr.exists(a)) return m_csr[a];
    if (a == A_VENDOR)   return VENDOR;
    if (a == A_ARCH)     return ARCH;
    return 32'd0;
  endfunction

  function automatic logic is_counter(input logic [11:0] a);
    return (a[11:8] == 4'hB);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
    m_csr.delete();
    m_csr[A_MSTATUS] = 32'h0000_1800;
    m_csr[A_MTVEC]   = 32'd0;
    m_csr[A_MEPC]    = 32'd0;
    m_csr[A_MCAUSE]  = 32'd0;
    m_minstret = 0;
    m_halted   = 1'b0;
    m_code     = 32'd0;
  endtask

  task automatic probe(input int kind, input logic [11:0] addr, input logic [31:0] exp);
    probe_t p;
    p.kind = kind;
    p.addr = addr;
    p.exp  = exp;
    pq.push_back(p);
  endtask

  // Present one instruction; if the model accepts it, update the model and queue its expectation
  task automatic issue(input logic [4:0] wa, input logic [31:0] wd, input logic cwen,
                       input logic [11:0] ca, input logic [31:0] cd);
    commit_t e;
    in_valid     = 1'b1;
    in_gpr_waddr = wa;
    in_gpr_wdata = wd;
    in_csr_wen   = cwen;
    in_csr_waddr = ca;
    in_csr_wdata = cd;
    if (!reset && !m_halted) begin
      if (wa != 5'd0) m_gpr[wa] = wd;
      m_minstret++;
      e.chk_csr = 1'b0;
      if (cwen) begin
        if (ca == 12'h000) begin
          m_halted = 1'b1;
          m_code   = m_gpr[10];
        end else begin
          if (m_csr.exists(ca)) m_csr[ca] = cd;
          e.chk_csr = !is_counter(ca);
        end
      end
      e.gaddr    = wa;
      e.gdata    = m_gpr[wa];
      e.caddr    = ca;
      e.cdata    = model_csr_read(ca);
      e.minstret = m_minstret;
      cq.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    in_valid   = 1'b0;
    in_csr_wen = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset    = 1'b1;
    in_valid = 1'b0;
    model_reset();
    repeat (n) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Monitor: owns rs2_addr and csr_raddr; checks each commit pulse and queued probes
  initial begin
    commit_t e;
    probe_t  p;
    rs2_addr  = 5'd0;
    csr_raddr = 12'd0;
    while (!done) begin
      @(negedge clock);
      if (commit === 1'b1) begin
        if (cq.size() == 0) begin
          chk("unexpected_commit", 32'd1, 32'd0);
        end else begin
          e = cq.pop_front();
          rs2_addr  = e.gaddr;
          csr_raddr = e.chk_csr ? e.caddr : A_MINSTRET;
          #1;
          chk($sformatf("commit_gpr_x%0d", e.gaddr), rs2_data, e.gdata);
          if (e.chk_csr) chk($sformatf("commit_csr_%h", e.caddr), csr_rdata, e.cdata);
          else           chk("commit_minstret", csr_rdata, e.minstret);
        end
      end
      while (pq.size() > 0) begin
        p = pq.pop_front();
        case (p.kind)
          P_GPR: begin
            rs2_addr = p.addr[4:0];
            #1;
            chk($sformatf("gpr_x%0d", p.addr), rs2_data, p.exp);
          end
          P_RS1: begin
            #1;
            chk($sformatf("rs1_bypass_x%0d", rs1_addr), rs1_data, p.exp);
          end
          P_CSR: begin
            csr_raddr = p.addr;
            #1;
            chk($sformatf("csr_%h", p.addr), csr_rdata, p.exp);
          end
          P_HALT:  chk("halt", {31'd0, halt}, p.exp);
          P_READY: chk("in_ready", {31'd0, in_ready}, p.exp);
          default: chk("halt_code", halt_code, p.exp);
        endcase
      end
    end
    chk("pending_commits", 32'(cq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  // Stimulus
  initial begin
    logic [4:0]  wa, pw;
    logic [11:0] ca, pc;
    logic        cwen;
    reset        = 1'b1;
    in_valid     = 1'b0;
    in_gpr_waddr = 5'd0;
    in_gpr_wdata = 32'd0;
    in_csr_wen   = 1'b0;
    in_csr_waddr = 12'd0;
    in_csr_wdata = 32'd0;
    rs1_addr     = 5'd0;
    do_reset(3);

    // Reset state
    for (int i = 0; i < 32; i++) probe(P_GPR, 12'(i), 32'd0);
    tick();
    probe(P_CSR, A_MSTATUS, 32'h0000_1800);
    probe(P_CSR, A_VENDOR, VENDOR);
    probe(P_CSR, A_ARCH, ARCH);
    probe(P_HALT, 0, 32'd0);
    probe(P_READY, 0, 32'd1);
    probe(P_CODE, 0, 32'd0);
    tick();

    // Three retirements from reset
    for (int i = 1; i <= 3; i++) begin
      issue(5'(i), $urandom, 1'b0, 12'd0, 32'd0);
      tick();
    end
    probe(P_CSR, A_MINSTRET, 32'd3);

    // GPR bypass and x0
    rs1_addr = 5'd5;
    issue(5'd5, 32'hDEAD_BEEF, 1'b0, 12'd0, 32'd0);
    probe(P_RS1, 0, 32'hDEAD_BEEF);
    tick();
    probe(P_RS1, 0, 32'hDEAD_BEEF);
    issue(5'd0, 32'd1, 1'b0, 12'd0, 32'd0);
    probe(P_GPR, 0, 32'd0);
    tick();

    // mtvec write, read-only mvendorid
    issue(5'd0, 32'd0, 1'b1, A_MTVEC, 32'h8000_0100);
    tick();
    issue(5'd0, 32'd0, 1'b1, A_VENDOR, 32'd0);
    tick();
    probe(P_CSR, A_MTVEC, 32'h8000_0100);
    probe(P_CSR, A_VENDOR, VENDOR);
    tick();

    // mcycle carry into mcycleh
    issue(5'd0, 32'd0, 1'b1, A_MCYCLEH, 32'd0);
    tick();
    issue(5'd0, 32'd0, 1'b1, A_MCYCLE, 32'hFFFF_FFFF);
    tick();
    tick();
    tick();
    probe(P_CSR, A_MCYCLEH, 32'd1);
    probe(P_CSR, A_MCYCLE, 32'd1);
    tick();

    // Random traffic; back-to-back commits never reuse a destination so the
    // registered check of one commit is not masked by the next one's bypass
    pw = 5'd0;
    pc = A_NONE;
    for (int n = 0; n < 300; n++) begin
      rs1_addr = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) begin
        do wa = 5'($urandom_range(0, 31)); while (wa != 5'd0 && wa == pw);
        cwen = ($urandom_range(0, 2) == 0);
        do ca = csr_pool[$urandom_range(0, 6)]; while (ca == pc);
        issue(wa, $urandom, cwen, ca, $urandom);
        pw = wa;
        pc = cwen ? ca : A_NONE;
      end else begin
        pw = 5'd0;
        pc = A_NONE;
      end
      probe(P_RS1, 0, m_gpr[rs1_addr]);
      if (n % 3 == 0) begin
        ca = csr_pool[$urandom_range(0, 6)];
        probe(P_CSR, ca, model_csr_read(ca));
      end
      tick();
    end
    tick();

    // ebreak and HALT behaviour in a fresh epoch
    do_reset(1);
    issue(5'd10, 32'd42, 1'b0, 12'd0, 32'd0);
    tick();
    issue(5'd0, 32'd0, 1'b1, 12'h000, 32'd0);
    tick();
    probe(P_HALT, 0, 32'd1);
    probe(P_CODE, 0, m_code);
    probe(P_READY, 0, 32'd0);
    rs1_addr = 5'd7;
    for (int k = 0; k < 4; k++) begin
      issue(5'd7, $urandom, 1'b1, A_MTVEC, $urandom);
      probe(P_RS1, 0, m_gpr[7]);
      probe(P_GPR, 7, m_gpr[7]);
      probe(P_CSR, A_MTVEC, model_csr_read(A_MTVEC));
      probe(P_CSR, A_MINSTRET, m_minstret);
      probe(P_CSR, A_MCYCLE, edges);
      tick();
    end

    // Reset out of HALT with an instruction in flight
    reset = 1'b1;
    model_reset();
    issue(5'd10, 32'd99, 1'b0, 12'd0, 32'd0);
    @(posedge clock);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    probe(P_HALT, 0, 32'd0);
    probe(P_READY, 0, 32'd1);
    probe(P_GPR, 10, 32'd0);
    probe(P_CSR, A_MCYCLE, 32'd0);
    probe(P_CODE, 0, 32'd0);
    tick();
    tick();
    done = 1'b1;
  end

endmodule
